mem_port_arbiter: RTL

Shares one single-port unified memory between the instruction-fetch and data-memory accesses of the 5-stage MIPS pipeline. It arbitrates fetch and data requests and sequences a req/ack handshake with the memory, which has variable latency. It returns read data to the winning requester and drives a pipeline stall. A watchdog aborts any access the memory never acknowledges, so the pipeline cannot hang.

---
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port unified memory between instruction fetch (I) and
//   data access (D) of a 5-stage MIPS pipeline. D has fixed priority over I.
//   Each access runs IDLE -> BUSY -> RESP. In BUSY the memory request is held
//   until m_ack, or until the watchdog aborts it after MAX_WAIT cycles.
//
// Handshakes:
//   Requester side: a requester raises *_req and holds it until its *_ready
//   pulse. *_ready is high for exactly one cycle, and the matching *_rdata is
//   valid in that cycle. *_rdata keeps that value until the next capture.
//   Memory side: m_req/m_we/m_addr/m_wdata are registered. They stay constant
//   while the access is outstanding. The memory answers with a one-cycle m_ack
//   that carries m_rdata. m_ack is ignored outside BUSY.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   i_req, i_addr              fetch request and address
//   i_rdata, i_ready           fetched word and completion pulse
//   d_req, d_we, d_addr        data request, store flag and address
//   d_wdata                    store data
//   d_rdata, d_ready           load data (or memory data on a store) and pulse
//   m_req, m_we, m_addr        registered memory request, write enable, address
//   m_wdata                    registered memory write data
//   m_rdata, m_ack             memory read data and one-cycle completion
//   stall                      combinational pipeline stall
//   err                        sticky flag: some access was aborted
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_WAIT = 16,
  parameter logic [DW-1:0] ABORT_DATA = 32'hDEADBEEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          stall,
  output logic          err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_I    = 2'd1;
  localparam logic [1:0] G_D    = 2'd2;

  // The counter can reach MAX_WAIT, so it needs room for that value.
  localparam int CW = $clog2(MAX_WAIT + 1);
  // A BUSY cycle that starts with the counter at MAX_WAIT-1 is the last one
  // allowed. If m_ack is still low in that cycle, the access is aborted.
  localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

  logic [1:0]    state;
  logic [1:0]    grant;
  logic [CW-1:0] wait_cnt;

  // The data to capture on leaving BUSY. An ack wins over the watchdog,
  // even in the very cycle that the watchdog expires.
  logic [DW-1:0] resp_data;
  assign resp_data = m_ack ? m_rdata : ABORT_DATA;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      grant    <= G_NONE;
      wait_cnt <= '0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      i_ready  <= 1'b0;
      d_ready  <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // D belongs to the older instruction, so it goes first.
          if (d_req) begin
            grant   <= G_D;
            m_addr  <= d_addr;
            m_we    <= d_we;
            m_wdata <= d_wdata;
            m_req   <= 1'b1;
            state   <= S_BUSY;
          end else if (i_req) begin
            grant   <= G_I;
            m_addr  <= i_addr;
            m_we    <= 1'b0;
            m_wdata <= '0;
            m_req   <= 1'b1;
            state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (m_ack || (wait_cnt == LAST_WAIT)) begin
            m_req <= 1'b0;
            m_we  <= 1'b0;
            state <= S_RESP;
            if (grant == G_D) begin
              d_rdata <= resp_data;
              d_ready <= 1'b1;
            end else begin
              i_rdata <= resp_data;
              i_ready <= 1'b1;
            end
            if (!m_ack) begin
              err <= 1'b1;
            end
          end
          if (!m_ack) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_RESP: begin
          // Requests are not sampled here. A requester that still holds req
          // in this cycle is not served a second time.
          i_ready  <= 1'b0;
          d_ready  <= 1'b0;
          wait_cnt <= '0;
          grant    <= G_NONE;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign stall = (i_req & ~i_ready) | (d_req & ~d_ready);

endmodule
